// File: rtl/drc_burst_scheduler.sv
// Splits one transfer request into AXI INCR burst descriptors. Each descriptor is
// released only after the data FIFO holds all of its beats. Optional counters: DRC_BURST_STATS_EN.
module drc_burst_scheduler #(
  parameter int p_max_beats = 128,
  parameter int p_cnt_w     = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  input  logic [23:0]        req_beats,
  input  logic [p_cnt_w-1:0] data_count,
  input  logic               data_rd,
  input  logic               burst_full,
  output logic               burst_wr,
  output logic [39:0]        burst_out,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef DRC_BURST_STATS_EN
  ,
  output logic [31:0]        stat_bursts,
  output logic [15:0]        stat_splits
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_WAIT, S_ISSUE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [23:0]        rem_q, rem_d;
  logic [7:0]         len_q, len_d;
  logic [p_cnt_w:0]   resv_q, resv_d;
  logic               err_q, err_d;

  logic [7:0]         cap, room_m1, len_calc;
  logic [p_cnt_w:0]   avail;
  logic               data_ok, rd_ok;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[3:0];

  // Page room is held as (room-1) so 256 fits in 8 bits; cap is never 0 in CALC.
  assign cap      = (rem_q > 24'(p_max_beats)) ? 8'(p_max_beats) : rem_q[7:0];
  assign room_m1  = 8'hFF - addr_q[11:4];
  assign len_calc = ((cap - 8'd1) <= room_m1) ? cap : room_m1 + 8'd1;

  // Signed availability: a set MSB means more beats are reserved than present.
  assign avail   = {1'b0, data_count} - resv_q;
  assign data_ok = !avail[p_cnt_w] && (avail >= (p_cnt_w+1)'(len_q));
  assign rd_ok   = data_rd && (resv_q != '0);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    len_d     = len_q;
    req_ready = 1'b0;
    burst_wr  = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = {req_addr[31:4], 4'h0};
          rem_d   = req_beats;
          state_d = (req_beats == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        len_d   = len_calc;
        state_d = S_WAIT;
      end
      S_WAIT: if (data_ok && !burst_full) state_d = S_ISSUE;
      S_ISSUE: begin
        // Re-checked here so a full that rises after WAIT still blocks the strobe.
        if (!burst_full) begin
          burst_wr = 1'b1;
          addr_d   = addr_q + {20'h0, len_q, 4'h0};
          rem_d    = rem_q - 24'(len_q);
          state_d  = (rem_q == 24'(len_q)) ? S_DONE : S_CALC;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resv_d    = resv_q + (burst_wr ? (p_cnt_w+1)'(len_q) : '0)
                            - {{p_cnt_w{1'b0}}, rd_ok};
  assign err_d     = err_q | (data_rd && (resv_q == '0));
  assign burst_out = burst_wr ? {addr_q, len_q} : 40'h0;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      resv_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      resv_q  <= resv_d;
      err_q   <= err_d;
    end
  end

`ifdef DRC_BURST_STATS_EN
  logic [31:0] bursts_q;
  logic [15:0] splits_q;
  logic        first_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bursts_q <= '0;
      splits_q <= '0;
      first_q  <= 1'b0;
    end else begin
      if (req_valid && req_ready) first_q <= 1'b1;
      else if (burst_wr)          first_q <= 1'b0;
      if (burst_wr) bursts_q <= bursts_q + 32'd1;
      // A first burst that leaves beats behind means the request was split.
      if (burst_wr && first_q && (rem_q != 24'(len_q))) splits_q <= splits_q + 16'd1;
    end
  end

  assign stat_bursts = bursts_q;
  assign stat_splits = splits_q;
`endif

endmodule
